// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared constants and terminal-count helper for the 74LS161-style counter
package ls_pkg;

    localparam int LS161_WIDTH = 4;

    // True when the low 'width' bits of value are all ones; width 0 yields 1.
    function automatic logic all_ones(input logic [31:0] value, input int width);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = r & value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ls161_stage.sv
// rtl/ls161_stage.sv - one counter bit: synchronous load has priority over toggle, async clear
module ls161_stage (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic din_bit,
    input  logic toggle,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din_bit;
        end else if (toggle) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ls161_counter.sv
// rtl/ls161_counter.sv - presettable binary counter with ripple-carry output, 74LS161 equivalent
module ls161_counter
    import ls_pkg::*;
#(
    parameter int WIDTH = LS161_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             n_load,
    input  logic             enp,
    input  logic             ent,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    logic [31:0]      q_ext;
    logic [WIDTH-1:0] low_ones;
    logic             count_en;

    assign q_ext    = 32'(q);
    assign count_en = enp & ent;

    // Carry-lookahead: bit i toggles when every lower bit is already one.
    always_comb begin
        low_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_ones[i] = all_ones(q_ext, i);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        ls161_stage u_stage (
            .clk     (clk),
            .clr     (clr),
            .load    (~n_load),
            .din_bit (din[g]),
            .toggle  (count_en & low_ones[g]),
            .q       (q[g])
        );
    end

    // Not gated by enp so cascaded stages see terminal count while held.
    assign rco = ent & (&q);

endmodule

// File: tb/tb_ls161_counter.sv
// tb/tb_ls161_counter.sv - self-checking bench: vector table, corner sequences, random model, cascade
module tb_ls161_counter;

    logic       clk;
    logic       clr;
    logic [3:0] din;
    logic       n_load;
    logic       enp;
    logic       ent;
    logic [3:0] q;
    logic       rco;

    logic       cclr;
    logic       cn_load;
    logic       cenp;
    logic       cent;
    logic [3:0] cdin0;
    logic [3:0] cdin1;
    logic [3:0] cq0;
    logic [3:0] cq1;
    logic       crco0;
    logic       crco1;

    int checks;
    int errors;

    ls161_counter #(.WIDTH(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .din    (din),
        .n_load (n_load),
        .enp    (enp),
        .ent    (ent),
        .q      (q),
        .rco    (rco)
    );

    ls161_counter #(.WIDTH(4)) c0 (
        .clk    (clk),
        .clr    (cclr),
        .din    (cdin0),
        .n_load (cn_load),
        .enp    (cenp),
        .ent    (cent),
        .q      (cq0),
        .rco    (crco0)
    );

    ls161_counter #(.WIDTH(4)) c1 (
        .clk    (clk),
        .clr    (cclr),
        .din    (cdin1),
        .n_load (cn_load),
        .enp    (cenp),
        .ent    (crco0),
        .q      (cq1),
        .rco    (crco1)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       n_load;
        logic [3:0] din;
        logic       enp;
        logic       ent;
        logic [3:0] exp_q;
        logic       exp_rco;
    } vec_t;

    vec_t vecs[21];

    int         mq;
    int         cv;
    logic       r_clr;
    logic       r_nl;
    logic       r_enp;
    logic       r_ent;
    logic [3:0] r_din;

    initial begin
        checks = 0;
        errors = 0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].n_load  = 1'b1;
            vecs[i].din     = 4'($urandom);
            vecs[i].enp     = 1'b1;
            vecs[i].ent     = 1'b1;
            vecs[i].exp_q   = 4'((i + 1) % 16);
            vecs[i].exp_rco = (((i + 1) % 16) == 15);
        end
        vecs[16] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'd10, 1'b0};
        vecs[17] = '{1'b1, 4'd3,    1'b1, 1'b1, 4'd11, 1'b0};
        vecs[18] = '{1'b1, 4'd0,    1'b1, 1'b1, 4'd12, 1'b0};
        vecs[19] = '{1'b0, 4'd15,   1'b0, 1'b1, 4'd15, 1'b1};
        vecs[20] = '{1'b1, 4'd7,    1'b0, 1'b1, 4'd15, 1'b1};

        // Reset before any clock edge
        clr    = 1'b1;
        din    = 4'($urandom);
        n_load = 1'($urandom);
        enp    = 1'($urandom);
        ent    = 1'($urandom);
        cclr   = 1'b1;
        cn_load = 1'b1;
        cenp   = 1'b0;
        cent   = 1'b0;
        cdin0  = 4'd0;
        cdin1  = 4'd0;
        #5;
        check("reset_q_pre_edge", q, 0);
        check("reset_rco_pre_edge", rco, 0);
        tick();
        check("reset_q_post_edge", q, 0);

        clr    = 1'b0;
        n_load = 1'b1;
        enp    = 1'b1;
        ent    = 1'b1;
        din    = 4'd0;

        for (int i = 0; i < 21; i++) begin
            n_load = vecs[i].n_load;
            din    = vecs[i].din;
            enp    = vecs[i].enp;
            ent    = vecs[i].ent;
            tick();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_rco", i), rco, vecs[i].exp_rco);
        end

        // ent drop is combinational
        ent = 1'b0;
        #2;
        check("ent_drop_rco", rco, 0);
        check("ent_drop_q", q, 15);
        ent = 1'b1;
        #1;
        check("ent_raise_rco", rco, 1);

        // Async clear mid-count at q=6
        n_load = 1'b0;
        din    = 4'd5;
        enp    = 1'b1;
        tick();
        check("preclr_load_q", q, 5);
        n_load = 1'b1;
        tick();
        check("preclr_count_q", q, 6);
        #4;
        clr = 1'b1;
        #1;
        check("async_clr_q", q, 0);
        check("async_clr_rco", rco, 0);
        #19;
        check("clr_held_over_edge_q", q, 0);
        clr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("post_clr_count%0d", i), q, i);
        end

        // Randomised stimulus against an arithmetic model
        mq = 3;
        for (int n = 0; n < 300; n++) begin
            r_clr = ($urandom_range(0, 15) == 0);
            r_nl  = ($urandom_range(0, 5) != 0);
            r_din = 4'($urandom);
            r_enp = ($urandom_range(0, 3) != 0);
            r_ent = ($urandom_range(0, 3) != 0);
            clr    = r_clr;
            n_load = r_nl;
            din    = r_din;
            enp    = r_enp;
            ent    = r_ent;
            if (r_clr) mq = 0;
            #1;
            check("rand_q_comb", q, mq);
            check("rand_rco_comb", rco, int'(r_ent && mq == 15));
            tick();
            if (!r_clr) begin
                if (!r_nl) mq = int'(r_din);
                else if (r_enp && r_ent) mq = (mq + 1) % 16;
            end
            check("rand_q", q, mq);
            check("rand_rco", rco, int'(r_ent && mq == 15));
        end
        clr = 1'b0;

        // Cascade: 8-bit count built from two stages
        cclr    = 1'b0;
        cn_load = 1'b0;
        cdin0   = 4'hE;
        cdin1   = 4'h0;
        cenp    = 1'b1;
        cent    = 1'b1;
        cv      = 14;
        tick();
        check("casc_load", {cq1, cq0}, cv);
        cn_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cv = (cv + 1) % 256;
            check($sformatf("casc_count%0d", i), {cq1, cq0}, cv);
            check($sformatf("casc_rco0_%0d", i), crco0, int'((cv % 16) == 15));
        end
        cenp = 1'b0;
        tick();
        check("casc_hold", {cq1, cq0}, cv);
        cenp    = 1'b1;
        cn_load = 1'b0;
        cdin0   = 4'hF;
        cdin1   = 4'hF;
        tick();
        check("casc_load_ff", {cq1, cq0}, 255);
        check("casc_rco1_ff", crco1, 1);
        cn_load = 1'b1;
        tick();
        check("casc_wrap", {cq1, cq0}, 0);
        check("casc_rco1_wrap", crco1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
